// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and frame constants for the 8N1 UART
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 217;
    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 10;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - CSR-side handshake bundle between the register block and the UART core
interface uart_if;

    logic [7:0] tx_data_i;
    logic       tx_wr_i;
    logic       tx_busy_o;
    logic [7:0] rx_data_o;
    logic       rx_rd_i;
    logic       rx_not_empty_o;
    logic       rx_overrun_o;
    logic       rx_frame_err_o;

    modport slave (
        input  tx_data_i, tx_wr_i, rx_rd_i,
        output tx_busy_o, rx_data_o, rx_not_empty_o, rx_overrun_o, rx_frame_err_o
    );

    modport master (
        output tx_data_i, tx_wr_i, rx_rd_i,
        input  tx_busy_o, rx_data_o, rx_not_empty_o, rx_overrun_o, rx_frame_err_o
    );

endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - RX synchronizer, mid-bit sampling FSM; emits a byte with a one-cycle valid
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                // Half-bit check rejects short low glitches and centres later samples.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {sync2_q, shreg_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                cnt_d = '0;
                if (sync2_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - 8N1 UART top: TX serializer, single-entry receive buffer with overrun
module uart_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    uart_if.slave csr,
    input  logic uart_rx_i,
    output logic uart_tx_o
);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shreg_q, tx_shreg_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_busy_q, tx_busy_d;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;
    logic [7:0] buf_data_q, buf_data_d;
    logic       buf_full_q, buf_full_d;
    logic       ovr_q, ovr_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shreg_q <= '0;
            tx_line_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            buf_data_q <= '0;
            buf_full_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shreg_q <= tx_shreg_d;
            tx_line_q  <= tx_line_d;
            tx_busy_q  <= tx_busy_d;
            buf_data_q <= buf_data_d;
            buf_full_q <= buf_full_d;
            ovr_q      <= ovr_d;
        end
    end

    // tx_bit_q tracks the frame position: 0 start, 1..8 data, 9 stop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shreg_d = tx_shreg_q;
        tx_line_d  = tx_line_q;
        tx_busy_d  = tx_busy_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d  = '0;
                tx_line_d = 1'b1;
                tx_busy_d = 1'b0;
                if (csr.tx_wr_i) begin
                    tx_state_d = TX_START;
                    tx_shreg_d = csr.tx_data_i;
                    tx_bit_d   = '0;
                    tx_line_d  = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = 4'd1;
                    tx_line_d  = tx_shreg_q[0];
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 1'b1;
                    if (tx_bit_q == 4'(DATA_BITS)) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_shreg_d = tx_shreg_q >> 1;
                        tx_line_d  = tx_shreg_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST && tx_bit_q == 4'(FRAME_BITS - 1)) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_busy_d  = 1'b0;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // A pop in the delivery cycle frees the slot, so the new byte lands without overrun.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_full_d = buf_full_q;
        ovr_d      = 1'b0;
        if (rx_valid) begin
            if (!buf_full_q || csr.rx_rd_i) begin
                buf_data_d = rx_byte;
                buf_full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (csr.rx_rd_i) begin
            buf_full_d = 1'b0;
        end
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_rx (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rx_i       (uart_rx_i),
        .byte_o     (rx_byte),
        .valid_o    (rx_valid),
        .frame_err_o(rx_ferr)
    );

    assign uart_tx_o          = tx_line_q;
    assign csr.tx_busy_o      = tx_busy_q;
    assign csr.rx_data_o      = buf_data_q;
    assign csr.rx_not_empty_o = buf_full_q;
    assign csr.rx_overrun_o   = ovr_q;
    assign csr.rx_frame_err_o = rx_ferr;

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- 8N1 UART serializer/deserializer that sits directly behind the UART_STATUS/UART_DATA CSR registers.
- Consumes the write strobe and data byte from the CSR block and serializes them onto the TX pin.
- Deserializes the RX pin into a single-entry receive buffer.
- Returns TX_BUSY, RX_NOT_EMPTY and the buffered byte, and pops the buffer on the CSR read strobe.

Parameters:
- CLKS_PER_BIT, 217, clk_i cycles per bit period (25 MHz / 115200); must be >= 4.
- CNT_W, 16, width of the bit-period counters; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- tx_data_i  in  8  byte to transmit (from UART_DATA_DATA_o)
- tx_wr_i  in  1  one-cycle transmit strobe (from UART_DATA_wr_o)
- tx_busy_o  out  1  transmitter busy (to UART_STATUS_TX_BUSY_i)
- rx_data_o  out  8  buffered received byte (to UART_DATA_DATA_i)
- rx_rd_i  in  1  one-cycle pop strobe (from UART_DATA_rd_o)
- rx_not_empty_o  out  1  buffer holds a byte (to UART_STATUS_RX_NOT_EMPTY_i)
- rx_overrun_o  out  1  one-cycle pulse: complete byte dropped because buffer full
- rx_frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- uart_rx_i  in  1  asynchronous serial input
- uart_tx_o  out  1  serial output, idle high

Behaviour:
- Reset values (asynchronous, on rst_n_i low):
  - uart_tx_o=1; tx_busy_o=0; rx_not_empty_o=0; rx_data_o=8'h00; both pulses 0.
  - Both FSMs return to IDLE.
  - The synchronizer flops reset to 1.
  - Reset mid-frame aborts the frame; TX drives high immediately.
- All outputs are registered, with no combinational path from input to output. rx_data_o is stable whenever rx_not_empty_o=1, because the CSR block samples it in the same cycle it asserts rx_rd_i.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: tx_wr_i=1 latches tx_data_i and enters START; tx_busy_o and uart_tx_o=0 are both visible the next cycle.
  - START: lasts CLKS_PER_BIT cycles with the line at 0.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - STOP: lasts CLKS_PER_BIT cycles at 1; tx_busy_o falls at the end, so a frame keeps busy high for exactly 10*CLKS_PER_BIT cycles.
  - tx_wr_i while tx_busy_o=1 is ignored, with no effect on the frame in flight.
  - tx_wr_i in the first IDLE cycle after STOP is accepted, giving back-to-back frames.
- RX path:
  - uart_rx_i passes through a 2-flop synchronizer; all decisions use the synchronized signal.
  - IDLE: a 1->0 transition enters START.
  - START: waits CLKS_PER_BIT/2 (floor). If the line is back to 1, it was a glitch: return to IDLE with no pulse. Otherwise go to DATA.
  - DATA: samples 8 bits, each CLKS_PER_BIT after the previous sample, shifting LSB first.
  - STOP: samples one CLKS_PER_BIT later.
    - Stop bit = 1: the byte is delivered. Go to IDLE.
    - Stop bit = 0: pulse rx_frame_err_o, discard the byte, and enter WAIT_HIGH. Stay there until the line reads 1, then go to IDLE.
- Receive buffer, single entry:
  - Delivery with buffer empty: rx_data_o is loaded and rx_not_empty_o is set the next cycle.
  - Delivery with buffer full and no rx_rd_i that cycle: the new byte is dropped, rx_overrun_o pulses, and the old byte is kept.
  - rx_rd_i with buffer full: rx_not_empty_o clears the next cycle; rx_data_o holds its value.
  - Same-cycle delivery and rx_rd_i: the new byte is loaded, rx_not_empty_o stays 1, and there is no overrun.
  - rx_rd_i with buffer empty: no effect.
- TX and RX are fully independent; a loopback (tx wired to rx) works.

Decomposition:
- Package uart_pkg:
  - TX state encodings (IDLE/START/DATA/STOP).
  - RX state encodings (IDLE/START/DATA/STOP/WAIT_HIGH).
  - DEFAULT_CLKS_PER_BIT=217.
  - Frame constants: DATA_BITS=8, FRAME_BITS=10.
- One natural sub-module, uart_rx: synchronizer, RX FSM and sampling counter. It outputs a byte plus a one-cycle valid pulse and the frame-error pulse.
- uart_core keeps the TX FSM, the receive buffer and the overrun logic.

Test Plan (CLKS_PER_BIT=4 on the bench):
- TX 8'hA5 with one tx_wr_i pulse -> uart_tx_o sequence 0,1,0,1,0,0,1,0,1,1, each level 4 cycles; tx_busy_o high exactly 40 cycles; a second tx_wr_i at cycle 10 is ignored.
- Loopback, two back-to-back writes 8'h3C then 8'hC3 (second issued the cycle busy falls) -> first byte received as 8'h3C; a pop in the delivery cycle of the second byte yields 8'hC3 with rx_not_empty_o staying 1 and no overrun.
- Drive 8'h55 onto uart_rx_i, then 8'h12 without popping -> rx_data_o=8'h55, rx_overrun_o pulses once, rx_data_o still 8'h55 after the second frame.
- Drive 8'h81 with stop bit 0, hold the line low 20 cycles, then a valid 8'h7E -> one rx_frame_err_o pulse, no delivery for 8'h81, then 8'h7E received.
- Low glitch of 1 cycle on idle uart_rx_i -> no delivery, no pulses, RX returns to IDLE.
- rst_n_i asserted mid-TX (during bit 3) and mid-RX -> uart_tx_o=1 and tx_busy_o=0 immediately, rx_not_empty_o=0; a fresh TX of 8'h01 afterwards is correct.
